// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU/DMA memory port arbiter: read-data ownership
// encodings, the default starvation limit and the counter width helper.
package mem_arb_pkg;

    localparam int STARVE_MAX_DEF = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } own_e;

    // Width needed to hold 0..max inclusive (at least one bit).
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, DMA and memory-side bus signals of the arbiter; the master modport is
// the arbiter's view, the slave modport is the surrounding system's view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [3:0]    cpu_mem_we;
    logic          cpu_mem_re;
    logic [AW-1:0] cpu_mem_addr;
    logic [DW-1:0] cpu_mem_wdata;
    logic [DW-1:0] cpu_mem_rdata;

    logic          dma_req;
    logic [3:0]    dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic [3:0]    mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  cpu_mem_we, cpu_mem_re, cpu_mem_addr, cpu_mem_wdata,
        output cpu_mem_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_we, mem_re, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output cpu_mem_we, cpu_mem_re, cpu_mem_addr, cpu_mem_wdata,
        input  cpu_mem_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_we, mem_re, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts consecutive cycles a DMA request has waited; at_max flags that the
// next request must be forced through ahead of the CPU.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter  int STARVE_MAX = STARVE_MAX_DEF,
    localparam int CW         = cnt_w(STARVE_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          dma_req,
    input  logic          dma_gnt,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    assign at_max = (cnt == CW'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (dma_gnt || !dma_req) begin
                cnt <= '0;
            end else if (!at_max) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: CPU has priority, DMA steals idle cycles and is
// forced through after STARVE_MAX waits; CPU read data is held across stalls.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                cpu_en,
    mem_port_arbiter_if.master  bus
);

    localparam int CW = cnt_w(STARVE_MAX);

    logic          run;
    logic          cpu_act;
    logic          dma_gnt;
    logic          dma_rd;
    logic          at_max;
    logic [CW-1:0] starve_cnt;
    own_e          own_q;
    own_e          own_d;
    logic          hold_vld;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    // Reset also forces the combinational grant/enable outputs low.
    assign run     = en & rst_n;
    assign cpu_act = bus.cpu_mem_re | (|bus.cpu_mem_we);
    assign dma_gnt = run & bus.dma_req & (~cpu_act | at_max);
    assign cpu_en  = run & ~(dma_gnt & cpu_act);
    assign dma_rd  = dma_gnt & (bus.dma_we == 4'd0);

    assign bus.dma_gnt = dma_gnt;

    arb_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .dma_req (bus.dma_req),
        .dma_gnt (dma_gnt),
        .cnt     (starve_cnt),
        .at_max  (at_max)
    );

    always_comb begin
        bus.mem_we = 4'd0;
        bus.mem_re = 1'b0;
        addr_mux   = bus.cpu_mem_addr;
        wdata_mux  = bus.cpu_mem_wdata;
        if (dma_gnt) begin
            bus.mem_we = bus.dma_we;
            bus.mem_re = (bus.dma_we == 4'd0);
            addr_mux   = bus.dma_addr;
            wdata_mux  = bus.dma_wdata;
        end else if (cpu_en) begin
            bus.mem_we = bus.cpu_mem_we;
            bus.mem_re = bus.cpu_mem_re;
        end
    end

    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

    // Ownership of mem_rdata in the cycle after the access was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q <= OWN_NONE;
        end else if (en) begin
            own_q <= own_d;
        end
    end

    always_comb begin
        own_d = OWN_NONE;
        if (dma_rd) begin
            own_d = OWN_DMA;
        end else if (cpu_en && bus.cpu_mem_re) begin
            own_d = OWN_CPU;
        end
    end

    assign bus.dma_rvalid = (own_q == OWN_DMA);
    assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;

    // A stalled CPU would miss its read word; park it until the CPU runs again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (en) begin
            if (own_q == OWN_CPU && !cpu_en && !hold_vld) begin
                hold_vld  <= 1'b1;
                hold_data <= bus.mem_rdata;
            end else if (cpu_en) begin
                hold_vld  <= 1'b0;
            end
        end
    end

    assign bus.cpu_mem_rdata = hold_vld ? hold_data : bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency memory.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic cpu_en;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .STARVE_MAX (8),
        .AW         (32),
        .DW         (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .cpu_en (cpu_en),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous memory, preloaded on its first clock edge.
    logic [31:0] mem [0:1023];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[32'h100 >> 2] <= 32'hA5A5_0100;
            mem[32'h104 >> 2] <= 32'h0BAD_F00D;
            mem[32'h200 >> 2] <= 32'hDEAD_BEEF;
            mem_init          <= 1'b1;
            bus.mem_rdata     <= 32'h0;
        end else begin
            if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[11:2]];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) mem[bus.mem_addr[11:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cpu_mem_we    = 4'd0;
        bus.cpu_mem_re    = 1'b0;
        bus.cpu_mem_addr  = 32'h0;
        bus.cpu_mem_wdata = 32'h0;
        bus.dma_req       = 1'b0;
        bus.dma_we        = 4'd0;
        bus.dma_addr      = 32'h0;
        bus.dma_wdata     = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);

        // Outputs stay low under reset even with requests present
        en = 1'b1; bus.dma_req = 1'b1; bus.cpu_mem_re = 1'b1; bus.cpu_mem_we = 4'hF;
        #1;
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_dma_gnt", {31'd0, bus.dma_gnt}, 32'd0);
        chk("rst_mem_we", {28'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_re", {31'd0, bus.mem_re}, 32'd0);
        chk("rst_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
        chk("rst_starve", 32'(dut.u_starve.cnt), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Steal: idle CPU, DMA read of 0x100
        @(negedge clk);
        bus.dma_req = 1'b1; bus.dma_addr = 32'h100;
        #1;
        chk("steal_gnt", {31'd0, bus.dma_gnt}, 32'd1);
        chk("steal_cpu_en", {31'd0, cpu_en}, 32'd1);
        chk("steal_mem_re", {31'd0, bus.mem_re}, 32'd1);
        chk("steal_mem_addr", bus.mem_addr, 32'h100);
        @(negedge clk);
        bus.dma_req = 1'b0;
        #1;
        chk("steal_rvalid", {31'd0, bus.dma_rvalid}, 32'd1);
        chk("steal_rdata", bus.dma_rdata, 32'hA5A5_0100);
        @(negedge clk);
        #1;
        chk("steal_rvalid_once", {31'd0, bus.dma_rvalid}, 32'd0);

        // Starvation: CPU reads 0x200 every cycle, DMA read of 0x104 waits 8 cycles
        @(negedge clk);
        bus.cpu_mem_re = 1'b1; bus.cpu_mem_addr = 32'h200;
        bus.dma_req = 1'b1; bus.dma_addr = 32'h104;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("starve_nognt_%0d", i), {31'd0, bus.dma_gnt}, 32'd0);
            chk($sformatf("starve_cnt_%0d", i), 32'(dut.u_starve.cnt), 32'(i));
        end
        @(negedge clk);
        bus.cpu_mem_addr = 32'h100;
        #1;
        chk("force_gnt", {31'd0, bus.dma_gnt}, 32'd1);
        chk("force_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("force_mem_addr", bus.mem_addr, 32'h104);
        chk("force_starve", 32'(dut.u_starve.cnt), 32'd8);
        @(negedge clk);
        bus.dma_req = 1'b0;
        #1;
        chk("hold_cpu_en", {31'd0, cpu_en}, 32'd1);
        chk("hold_cpu_rdata", bus.cpu_mem_rdata, 32'hDEAD_BEEF);
        chk("hold_dma_rvalid", {31'd0, bus.dma_rvalid}, 32'd1);
        chk("hold_dma_rdata", bus.dma_rdata, 32'h0BAD_F00D);
        chk("post_force_starve", 32'(dut.u_starve.cnt), 32'd0);
        @(negedge clk);
        bus.cpu_mem_re = 1'b0;
        #1;
        chk("hold_released_rdata", bus.cpu_mem_rdata, 32'hA5A5_0100);

        // Write collision at 0x300: DMA forced first, CPU write lands after
        @(negedge clk);
        bus.cpu_mem_we = 4'hF; bus.cpu_mem_addr = 32'h300; bus.cpu_mem_wdata = 32'h2222_2222;
        bus.dma_req = 1'b1; bus.dma_we = 4'hF; bus.dma_addr = 32'h300; bus.dma_wdata = 32'h1111_1111;
        repeat (7) @(negedge clk);
        @(negedge clk);
        #1;
        chk("coll_gnt", {31'd0, bus.dma_gnt}, 32'd1);
        chk("coll_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("coll_mem_wdata", bus.mem_wdata, 32'h1111_1111);
        chk("coll_mem_we", {28'd0, bus.mem_we}, 32'hF);
        @(negedge clk);
        bus.dma_req = 1'b0; bus.dma_we = 4'd0;
        #1;
        chk("coll_dma_landed", mem[32'h300 >> 2], 32'h1111_1111);
        chk("coll_no_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
        chk("coll_cpu_wdata", bus.mem_wdata, 32'h2222_2222);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("coll_last_writer", mem[32'h300 >> 2], 32'h2222_2222);

        // Enable low: build starve count to 3, then freeze for 3 cycles
        @(negedge clk);
        bus.cpu_mem_re = 1'b1; bus.cpu_mem_addr = 32'h200;
        bus.dma_req = 1'b1; bus.dma_addr = 32'h104;
        repeat (3) @(negedge clk);
        en = 1'b0;
        bus.cpu_mem_re = 1'b0; bus.cpu_mem_we = 4'hF;
        bus.cpu_mem_addr = 32'h300; bus.cpu_mem_wdata = 32'h3333_3333;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("en_lo_gnt_%0d", i), {31'd0, bus.dma_gnt}, 32'd0);
            chk($sformatf("en_lo_we_%0d", i), {28'd0, bus.mem_we}, 32'd0);
            chk($sformatf("en_lo_cpu_en_%0d", i), {31'd0, cpu_en}, 32'd0);
            chk($sformatf("en_lo_starve_%0d", i), 32'(dut.u_starve.cnt), 32'd3);
        end
        @(negedge clk);
        en = 1'b1;
        bus.cpu_mem_we = 4'd0; bus.cpu_mem_re = 1'b1; bus.cpu_mem_addr = 32'h200;
        #1;
        chk("en_hi_starve", 32'(dut.u_starve.cnt), 32'd3);
        chk("en_lo_no_write", mem[32'h300 >> 2], 32'h2222_2222);
        @(negedge clk);
        idle_inputs();

        // Reset in the cycle after a DMA read grant drops the read
        @(negedge clk);
        bus.dma_req = 1'b1; bus.dma_addr = 32'h100;
        #1;
        chk("rr_gnt", {31'd0, bus.dma_gnt}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.cpu_mem_re = 1'b1;
        #1;
        chk("rr_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
        chk("rr_rdata", bus.dma_rdata, 32'd0);
        chk("rr_gnt_low", {31'd0, bus.dma_gnt}, 32'd0);
        chk("rr_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rr_mem_re", {31'd0, bus.mem_re}, 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        chk("rr_release_cpu_en", {31'd0, cpu_en}, 32'd1);
        @(negedge clk);
        #1;
        chk("rr_no_late_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
